// File: rtl/torrence_types.sv
// ============================================================================
// Module      : torrence_types
// Description : Shared types for the cache subsystem: memory access sizes and
//               the line-mover FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package torrence_types;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_operation_size_e;

  typedef enum logic [2:0] {
    CLM_IDLE      = 3'd0,
    CLM_EVICT     = 3'd1,
    CLM_FILL_REQ  = 3'd2,
    CLM_FILL_WAIT = 3'd3,
    CLM_DONE      = 3'd4
  } cache_line_mover_state_e;

endpackage

`default_nettype wire

// File: rtl/cache_line_mover.sv
// ============================================================================
// Module      : cache_line_mover
// Description : Moves one cache line between the data array and main memory:
//               optional word-by-word write-back of the victim, then refill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_line_mover
  import torrence_types::*;
#(
  parameter int XLEN           = 32,
  parameter int SET_SIZE       = 2,
  parameter int WORDS_PER_LINE = 8,
  parameter int ASSOC          = 1,
  localparam int WORD_SEL      = $clog2(WORDS_PER_LINE),
  localparam int ASSOC_SIZE    = (ASSOC > 1) ? $clog2(ASSOC) : 1,
  localparam int TAG_SIZE      = XLEN - SET_SIZE - WORD_SEL - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_evict,
  input  logic [SET_SIZE-1:0]    req_set,
  input  logic [ASSOC_SIZE-1:0]  req_way,
  input  logic [TAG_SIZE-1:0]    req_evict_tag,
  input  logic [TAG_SIZE-1:0]    req_fill_tag,
  output logic                   done,
  output logic                   dl_perform_write,
  output logic [SET_SIZE-1:0]    dl_set,
  output logic [ASSOC_SIZE-1:0]  dl_selected_way,
  output logic [WORD_SEL-1:0]    dl_word_select,
  output memory_operation_size_e dl_op_size,
  output logic [XLEN-1:0]        dl_word_to_store,
  input  logic [XLEN-1:0]        dl_fetched_word,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_write,
  output logic [XLEN-1:0]        mem_req_addr,
  output logic [XLEN-1:0]        mem_req_wdata,
  input  logic                   mem_rsp_valid,
  input  logic [XLEN-1:0]        mem_rsp_rdata
);

  localparam logic [WORD_SEL-1:0] LAST_WORD = WORD_SEL'(WORDS_PER_LINE - 1);
  localparam logic [WORD_SEL-1:0] CNT_ONE   = WORD_SEL'(1);

  cache_line_mover_state_e state_q, state_d;
  logic [WORD_SEL-1:0]     cnt_q, cnt_d;
  logic [SET_SIZE-1:0]     set_q;
  logic [ASSOC_SIZE-1:0]   way_q;
  logic [TAG_SIZE-1:0]     evict_tag_q;
  logic [TAG_SIZE-1:0]     fill_tag_q;

  // The line length is a power of two, so the counter wraps back to zero on
  // the last word of each phase without an explicit clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLM_IDLE: begin
        if (req_valid) begin
          state_d = req_evict ? CLM_EVICT : CLM_FILL_REQ;
          cnt_d   = '0;
        end
      end
      CLM_EVICT: begin
        if (mem_req_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_WORD) state_d = CLM_FILL_REQ;
        end
      end
      CLM_FILL_REQ: begin
        if (mem_req_ready) state_d = CLM_FILL_WAIT;
      end
      CLM_FILL_WAIT: begin
        if (mem_rsp_valid) begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_q == LAST_WORD) ? CLM_DONE : CLM_FILL_REQ;
        end
      end
      CLM_DONE: state_d = CLM_IDLE;
      default: begin
        state_d = CLM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLM_IDLE;
      cnt_q       <= '0;
      set_q       <= '0;
      way_q       <= '0;
      evict_tag_q <= '0;
      fill_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == CLM_IDLE && req_valid) begin
        set_q       <= req_set;
        way_q       <= req_way;
        evict_tag_q <= req_evict_tag;
        fill_tag_q  <= req_fill_tag;
      end
    end
  end

  assign req_ready = (state_q == CLM_IDLE);

  always_comb begin
    done             = 1'b0;
    dl_perform_write = 1'b0;
    dl_set           = set_q;
    dl_selected_way  = way_q;
    dl_word_select   = '0;
    dl_op_size       = WORD;
    dl_word_to_store = '0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    case (state_q)
      CLM_EVICT: begin
        mem_req_valid  = 1'b1;
        mem_req_write  = 1'b1;
        mem_req_addr   = {evict_tag_q, set_q, cnt_q, 2'b00};
        mem_req_wdata  = dl_fetched_word;
        dl_word_select = cnt_q;
      end
      CLM_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {fill_tag_q, set_q, cnt_q, 2'b00};
      end
      CLM_FILL_WAIT: begin
        // A response landing in the reset cycle must not reach the array.
        if (mem_rsp_valid && !reset) begin
          dl_perform_write = 1'b1;
          dl_word_to_store = mem_rsp_rdata;
          dl_word_select   = cnt_q;
        end
      end
      CLM_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
